alu_issue_unit: RTL
===================

# alu_issue_unit

Multi-cycle issue/write-back controller that sits directly upstream and downstream of the 32-bit ALU. It owns the 32×32 register file, accepts one decoded instruction at a time over a valid/ready handshake, and drives the ALU operand, function and shift-amount inputs. It produces the rising `alu_ena` edge the ALU evaluates on, captures `res1`/`res2` and the four flags, and writes results back.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `NREG`, 32, register count; `REG_AW` = log2(`NREG`) = 5

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  decoded instruction present
- `instr_ready`  out  1  unit can accept an instruction
- `rs`, `rt`, `rd`  in  5 each  source 1, source 2, destination register
- `shamt`  in  5  immediate shift amount
- `func`  in  6  ALU operation code
- `alu_inp1`, `alu_inp2`  out  32  operands to the ALU
- `alu_shamt`  out  5  shift amount to the ALU
- `alu_func`  out  6  operation to the ALU
- `alu_ena`  out  1  ALU trigger; a 0→1 edge starts evaluation
- `alu_res1`, `alu_res2`  in  32  ALU results
- `alu_carry`, `alu_sign`, `alu_ovf`, `alu_zero`  in  1 each  ALU flags
- `flags_q`  out  4  registered {carry, sign, overflow, zero}
- `wb_done`  out  1  one-cycle pulse when the instruction retires
- `illegal`  out  1  one-cycle pulse when the instruction is rejected
- `dbg_we`  in  1  register-file write for preload
- `dbg_waddr`  in  5  preload write address
- `dbg_wdata`  in  32  preload write data
- `dbg_raddr`  in  5  debug read address
- `dbg_rdata`  out  32  combinational read of `dbg_raddr`

## Operation
- Legal `func` values: 0 add, 2 signed mul, 3–11 (negate, and, xor, sll, srl, sllv, srlv, sra, srav). All other values (1, 12–63) are illegal.
- States: IDLE → READ → FIRE → CAPTURE → WB → (WB2 if func==2) → IDLE.
- IDLE:
  - `instr_ready`=1. On `instr_valid & instr_ready`, latch rs/rt/rd/shamt/func.
  - If `func` is illegal: pulse `illegal` next cycle, stay in IDLE, no register or flag change.
- READ: drive `alu_inp1`=R[rs], `alu_inp2`=R[rt], `alu_shamt`, `alu_func`; `alu_ena`=0.
- FIRE: `alu_ena`=1 while the operand outputs are held stable.
- CAPTURE: `alu_ena`=0. Latch `alu_res1`, `alu_res2` and the flags; flags go into `flags_q`.
- WB: R[rd] ← res1. For func≠2, pulse `wb_done` and return to IDLE.
- WB2 (func==2 only): R[(rd+1) mod 32] ← res2 (low word); pulse `wb_done`.
- Register file:
  - R0 reads 0; writes to R0 are dropped, including the WB2 wrap case rd=31 → R0.
  - rs or rt equal to rd of the previous instruction reads the written-back value; no hazard exists because the unit is strictly serial.
- `dbg_we` is honoured only in IDLE and not in the cycle an instruction is accepted. It is ignored in all other states.

## Timing
- Accept at cycle 0. READ in cycle 1, `alu_ena` high in cycle 2, CAPTURE in cycle 3, write and `wb_done` in cycle 4. Multiply writes res2 and pulses `wb_done` in cycle 5.
- `instr_ready` is high again in the cycle after `wb_done`, so throughput is one instruction per 5 cycles (6 for multiply).
- `illegal` is asserted in cycle 1; `instr_ready` is high again in cycle 1.
- Reset values:
  - all registers 0, `flags_q`=0
  - `alu_inp1`/`alu_inp2`/`alu_shamt`/`alu_func`=0, `alu_ena`=0
  - `wb_done`=0, `illegal`=0
  - state IDLE; `instr_ready`=1 in the first cycle after `rst` deasserts, 0 while `rst` is high.
- Reset mid-operation: the state returns to IDLE and `alu_ena` falls on the same edge. A pending write-back is discarded and the registers clear.
- `alu_ena` is never high in two consecutive cycles. It always returns to 0 before the next FIRE.

## Structure
- Shared package `alu_pkg`:
  - func code constants (`FN_ADD`=0, `FN_MULS`=2, `FN_NEG`=3 … `FN_SRAV`=11)
  - `is_legal_func` function
  - flag bit indices (CARRY=3, SIGN=2, OVF=1, ZERO=0)
  - issue FSM state enum
- Sub-module `regfile_2r1w`:
  - two combinational read ports plus a debug read port
  - one synchronous write port, R0 hardwired to 0
  - the WB/WB2 write and the debug write are muxed onto its single write port.

## Test plan
- Preload R1=5, R2=7; add rd=3 → `alu_ena` high in cycle 2 only, R3=12, `flags_q`=0000, `wb_done` in cycle 4.
- Preload R1=0x7FFFFFFF, R2=1; add → R3=0x80000000, `flags_q`={0,1,1,0}.
- Preload R1=−3 (0xFFFFFFFD), R2=4; signed mul rd=31 → R31=0xFFFFFFFF, R0 stays 0 (dropped wrap write), `wb_done` in cycle 5.
- sra with R1=0x80000000, shamt=4 → R[rd]=0xF8000000, sign flag 1. sll shamt=0 → value unchanged.
- func=1 and func=12 → `illegal` pulse in cycle 1, no `alu_ena` edge, registers and `flags_q` unchanged.
- Assert `rst` during FIRE → `alu_ena`=0 on the next edge, R[rd] not written, `instr_ready`=1 one cycle after reset releases.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/write-back controller: function codes,
// flag bit positions, the issue FSM state type and the legality check.
package alu_pkg;

  localparam logic [5:0] FN_ADD  = 6'd0;
  localparam logic [5:0] FN_MULS = 6'd2;
  localparam logic [5:0] FN_NEG  = 6'd3;
  localparam logic [5:0] FN_AND  = 6'd4;
  localparam logic [5:0] FN_XOR  = 6'd5;
  localparam logic [5:0] FN_SLL  = 6'd6;
  localparam logic [5:0] FN_SRL  = 6'd7;
  localparam logic [5:0] FN_SLLV = 6'd8;
  localparam logic [5:0] FN_SRLV = 6'd9;
  localparam logic [5:0] FN_SRA  = 6'd10;
  localparam logic [5:0] FN_SRAV = 6'd11;

  // Bit positions inside the 4-bit flag word {carry, sign, overflow, zero}
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FIRE,
    ST_CAPTURE,
    ST_WB,
    ST_WB2
  } issue_state_e;

  // Add, signed multiply and the contiguous block neg..srav are the only
  // operations the ALU implements.
  function automatic logic is_legal_func(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_MULS) || ((f >= FN_NEG) && (f <= FN_SRAV));
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two operand read ports, one debug read port and a single
// synchronous write port. Entry 0 always reads as zero and ignores writes.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     raddr3,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3
);

  logic [DATA_W-1:0] mem_q [NREG];

  // Clear every entry on reset; afterwards accept writes to any entry but 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
  assign rdata3 = (raddr3 == '0) ? '0 : mem_q[raddr3];

endmodule

// File: rtl/alu_issue_unit.sv
// Serial issue/write-back controller for the 32-bit ALU. Accepts one decoded
// instruction, presents operands, pulses alu_ena for exactly one cycle,
// captures results/flags and writes them back to the register file.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_func,
  output logic              alu_ena,
  input  logic [DATA_W-1:0] alu_res1,
  input  logic [DATA_W-1:0] alu_res2,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic              alu_ovf,
  input  logic              alu_zero,
  output logic [3:0]        flags_q,
  output logic              wb_done,
  output logic              illegal,
  input  logic              dbg_we,
  input  logic [REG_AW-1:0] dbg_waddr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  issue_state_e      state_q, state_d;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_inp1_q, alu_inp2_q, res1_q, res2_q;
  logic [4:0]        alu_shamt_q;
  logic [5:0]        alu_func_q;
  logic              alu_ena_q, illegal_q;

  logic              accept, func_legal;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign func_legal  = is_legal_func(func);

  // Operands are read straight from the incoming rs/rt on the accept edge, so
  // a result written back by the previous instruction is already visible.
  regfile_2r1w #(.DATA_W(DATA_W), .NREG(NREG), .AW(REG_AW)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs),
    .raddr2 (rt),
    .raddr3 (dbg_raddr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .rdata3 (dbg_rdata)
  );

  // Issue FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, write-port mux and retire pulse
  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_waddr = dbg_waddr;
    rf_wdata = dbg_wdata;
    wb_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Debug preload loses to an instruction arriving in the same cycle
        rf_we = dbg_we && !accept;
        if (accept && func_legal) state_d = ST_READ;
      end
      ST_READ:    state_d = ST_FIRE;
      ST_FIRE:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WB;
      ST_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = res1_q;
        if (alu_func_q == FN_MULS) begin
          state_d = ST_WB2;
        end else begin
          state_d = ST_IDLE;
          wb_done = 1'b1;
        end
      end
      ST_WB2: begin
        // Low product word goes to rd+1; rd=31 wraps onto R0 and is dropped
        rf_we    = 1'b1;
        rf_waddr = rd_q + REG_AW'(1);
        rf_wdata = res2_q;
        wb_done  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/ALU-control registers, result capture and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= '0;
      alu_inp1_q  <= '0;
      alu_inp2_q  <= '0;
      alu_shamt_q <= '0;
      alu_func_q  <= '0;
      alu_ena_q   <= 1'b0;
      res1_q      <= '0;
      res2_q      <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= accept && !func_legal;
      alu_ena_q <= (state_d == ST_FIRE);
      if (accept && func_legal) begin
        rd_q        <= rd;
        alu_inp1_q  <= rf_rdata1;
        alu_inp2_q  <= rf_rdata2;
        alu_shamt_q <= shamt;
        alu_func_q  <= func;
      end
      if (state_q == ST_CAPTURE) begin
        res1_q              <= alu_res1;
        res2_q              <= alu_res2;
        flags_q[FLAG_CARRY] <= alu_carry;
        flags_q[FLAG_SIGN]  <= alu_sign;
        flags_q[FLAG_OVF]   <= alu_ovf;
        flags_q[FLAG_ZERO]  <= alu_zero;
      end
    end
  end

  assign alu_inp1  = alu_inp1_q;
  assign alu_inp2  = alu_inp2_q;
  assign alu_shamt = alu_shamt_q;
  assign alu_func  = alu_func_q;
  assign alu_ena   = alu_ena_q;
  assign illegal   = illegal_q;

endmodule
